// File: rtl/window_fetch_ctrl.sv
// 3x3 window fetcher: streams edge-clamped pixel reads to a ROM and assembles
// the returned pixels into a sliding 3-column window.
module window_fetch_ctrl #(
    parameter int IMG_W   = 224,
    parameter int IMG_H   = 224,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 16,
    parameter int ROM_LAT = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_first,
    input  logic [7:0]            i_x,
    input  logic [7:0]            i_y,
    output logic                  o_rom_en,
    output logic [ADDR_W-1:0]     o_rom_addr,
    input  logic [DATA_W-1:0]     i_rom_data,
    output logic                  o_busy,
    output logic [9*DATA_W-1:0]   o_win,
    output logic                  o_win_valid
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    localparam logic [9:0] COL_MAX = 10'(IMG_W - 1);
    localparam logic [9:0] ROW_MAX = 10'(IMG_H - 1);

    state_t state, nxt_state;

    logic [7:0]  x_q, y_q;
    logic [1:0]  col_off, row_off;
    logic        load, adv, done;

    logic [7:0]  gen_x, gen_y;
    logic [1:0]  gen_col_off, gen_row_off;
    logic [9:0]  col_sum, row_sum, col_cl, row_cl;
    logic [ADDR_W-1:0] gen_addr;

    logic [ROM_LAT:1] vld_pipe;
    logic [1:0]       row_pipe [1:ROM_LAT];
    logic             cap_vld, cap_last;
    logic [1:0]       cap_row;

    logic [2:0][DATA_W-1:0]      col_buf;
    logic [2:0][2:0][DATA_W-1:0] win;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= nxt_state;
    end

    // A slide starts at column offset 2, so both read kinds end at offset (2,2).
    always_comb begin
        nxt_state = state;
        load      = 1'b0;
        adv       = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    nxt_state = ISSUE;
                    load      = 1'b1;
                end
            end
            ISSUE: begin
                if (col_off == 2'd2 && row_off == 2'd2) nxt_state = DRAIN;
                else                                    adv       = 1'b1;
            end
            DRAIN: begin
                if (cap_last) begin
                    nxt_state = IDLE;
                    done      = 1'b1;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_comb begin
        gen_x = load ? i_x : x_q;
        gen_y = load ? i_y : y_q;
        if (load) begin
            gen_col_off = i_first ? 2'd0 : 2'd2;
            gen_row_off = 2'd0;
        end else if (row_off == 2'd2) begin
            gen_col_off = col_off + 2'd1;
            gen_row_off = 2'd0;
        end else begin
            gen_col_off = col_off;
            gen_row_off = row_off + 2'd1;
        end
        col_sum  = {2'b00, gen_x} + {8'd0, gen_col_off};
        row_sum  = {2'b00, gen_y} + {8'd0, gen_row_off};
        col_cl   = (col_sum > COL_MAX) ? COL_MAX : col_sum;
        row_cl   = (row_sum > ROW_MAX) ? ROW_MAX : row_sum;
        gen_addr = ADDR_W'(row_cl) * ADDR_W'(IMG_W) + ADDR_W'(col_cl);
    end

    assign o_busy   = (state != IDLE);
    assign o_rom_en = (state == ISSUE);
    assign cap_vld  = vld_pipe[ROM_LAT];
    assign cap_row  = row_pipe[ROM_LAT];
    assign cap_last = cap_vld && (cap_row == 2'd2);
    assign o_win    = win;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            x_q         <= '0;
            y_q         <= '0;
            col_off     <= '0;
            row_off     <= '0;
            o_rom_addr  <= '0;
            vld_pipe    <= '0;
            for (int i = 1; i <= ROM_LAT; i++) row_pipe[i] <= '0;
            col_buf     <= '0;
            win         <= '0;
            o_win_valid <= 1'b0;
        end else begin
            vld_pipe[1] <= o_rom_en;
            row_pipe[1] <= row_off;
            for (int i = 2; i <= ROM_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                row_pipe[i] <= row_pipe[i-1];
            end
            if (load) begin
                x_q <= i_x;
                y_q <= i_y;
            end
            if (load || adv) begin
                col_off    <= gen_col_off;
                row_off    <= gen_row_off;
                o_rom_addr <= gen_addr;
            end
            if (cap_vld) col_buf[cap_row] <= i_rom_data;
            // Row 2 is taken straight from the ROM so the shift lands on the capture edge.
            if (cap_last) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                    win[r][2] <= (r == 2) ? i_rom_data : col_buf[r];
                end
            end
            o_win_valid <= done;
        end
    end

endmodule

// File: tb/tb_window_fetch_ctrl.sv
// Bench for window_fetch_ctrl: ROM_LAT=1 and ROM_LAT=2 instances, scoreboarded
// read addresses, windows and valid timing against a pixel model.
module tb_window_fetch_ctrl;

    localparam int IMG_W = 224;
    localparam int IMG_H = 224;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start [2];
    logic        first [2];
    logic [7:0]  xs [2];
    logic [7:0]  ys [2];
    logic        en [2];
    logic [15:0] addr [2];
    logic [7:0]  rdata [2];
    logic        busy [2];
    logic [71:0] win [2];
    logic        valid [2];

    window_fetch_ctrl #(.ROM_LAT(1)) u_lat1 (
        .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_first(first[0]),
        .i_x(xs[0]), .i_y(ys[0]), .o_rom_en(en[0]), .o_rom_addr(addr[0]),
        .i_rom_data(rdata[0]), .o_busy(busy[0]), .o_win(win[0]), .o_win_valid(valid[0]));

    window_fetch_ctrl #(.ROM_LAT(2)) u_lat2 (
        .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_first(first[1]),
        .i_x(xs[1]), .i_y(ys[1]), .o_rom_en(en[1]), .o_rom_addr(addr[1]),
        .i_rom_data(rdata[1]), .o_busy(busy[1]), .o_win(win[1]), .o_win_valid(valid[1]));

    always #5 clk = ~clk;

    // ROM contents: ROM[a] = a[7:0]
    logic [7:0] r1_q = 8'd0, r2_a = 8'd0, r2_b = 8'd0;
    always @(posedge clk) begin
        if (en[0]) r1_q <= addr[0][7:0];
        if (en[1]) r2_a <= addr[1][7:0];
        r2_b <= r2_a;
    end
    assign rdata[0] = r1_q;
    assign rdata[1] = r2_b;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] qa [2][$];
    logic [71:0] qw [2][$];
    int          qc [2][$];
    int          n_chk = 0, n_pass = 0;
    int          vcnt [2];
    int          rd_cnt [2];
    logic [15:0] last_addr [2];
    logic [71:0] last_win [2];
    logic [71:0] mwin [2];

    function automatic int clx(int c); return (c > IMG_W - 1) ? IMG_W - 1 : c; endfunction
    function automatic int cly(int r); return (r > IMG_H - 1) ? IMG_H - 1 : r; endfunction
    function automatic logic [15:0] a_of(int c, int r);
        return 16'(cly(r) * IMG_W + clx(c));
    endfunction

    task automatic chk(string name, logic [71:0] act, logic [71:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail(string name);
        n_chk++;
        $display("FAIL %s: expected event missing or unexpected event (cycle %0d)", name, cyc);
    endtask

    // Called in the cycle whose closing edge samples i_start.
    task automatic expect_start(int d, logic f, int x, int y);
        int          e = cyc + 1;
        int          n = f ? 9 : 3;
        logic [71:0] w = mwin[d];
        logic [15:0] a;
        for (int c = (f ? 0 : 2); c < 3; c++)
            for (int r = 0; r < 3; r++) qa[d].push_back(a_of(x + c, y + r));
        for (int r = 0; r < 3; r++) begin
            if (f) begin
                for (int c = 0; c < 3; c++) begin
                    a = a_of(x + c, y + r);
                    w[(3*r+c)*8 +: 8] = a[7:0];
                end
            end else begin
                a = a_of(x + 2, y + r);
                w[(3*r)*8 +: 8]   = mwin[d][(3*r+1)*8 +: 8];
                w[(3*r+1)*8 +: 8] = mwin[d][(3*r+2)*8 +: 8];
                w[(3*r+2)*8 +: 8] = a[7:0];
            end
        end
        mwin[d] = w;
        qw[d].push_back(w);
        qc[d].push_back(e + n + ((d == 0) ? 1 : 2));
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (en[d]) begin
                rd_cnt[d]++;
                last_addr[d] = addr[d];
                if (qa[d].size() == 0) fail($sformatf("unexpected_read dut%0d addr %0d", d, addr[d]));
                else chk($sformatf("rom_addr dut%0d", d), 72'(addr[d]), 72'(qa[d].pop_front()));
            end
            if (valid[d]) begin
                vcnt[d]++;
                last_win[d] = win[d];
                if (qw[d].size() == 0) fail($sformatf("unexpected_valid dut%0d", d));
                else begin
                    chk($sformatf("window dut%0d", d), win[d], qw[d].pop_front());
                    chk($sformatf("valid_cycle dut%0d", d), 72'(cyc), 72'(qc[d].pop_front()));
                end
            end
        end
    end

    task automatic wait_done(int d);
        int t = 0;
        while (qw[d].size() != 0 && t < 60) begin
            @(negedge clk); #1;
            t++;
        end
        if (qw[d].size() != 0) begin
            fail($sformatf("window_timeout dut%0d", d));
            qw[d].delete();
            qc[d].delete();
        end
        chk($sformatf("pending_reads dut%0d", d), 72'(qa[d].size()), 72'd0);
        qa[d].delete();
    endtask

    task automatic run(int d, logic f, int x, int y);
        start[d] = 1'b1;
        first[d] = f;
        xs[d]    = 8'(x);
        ys[d]    = 8'(y);
        expect_start(d, f, x, y);
        @(negedge clk); #1;
        start[d] = 1'b0;
        wait_done(d);
    endtask

    typedef struct {
        int          d;
        logic        f;
        int          x;
        int          y;
        int          n;
        logic [15:0] last;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          r0, v0;
        logic [15:0] la;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0; first[d] = 1'b0; xs[d] = '0; ys[d] = '0;
            vcnt[d] = 0; rd_cnt[d] = 0; last_addr[d] = '0; last_win[d] = '0; mwin[d] = '0;
        end
        tbl[0] = '{0, 1'b1, 0,   0,   9, 16'd450};
        tbl[1] = '{0, 1'b0, 1,   0,   3, 16'd451};
        tbl[2] = '{0, 1'b1, 222, 222, 9, 16'd50175};
        tbl[3] = '{0, 1'b0, 223, 222, 3, 16'd50175};
        tbl[4] = '{0, 1'b1, 100, 50,  9, 16'd11750};
        tbl[5] = '{0, 1'b0, 101, 50,  3, 16'd11751};
        tbl[6] = '{1, 1'b1, 9,   20,  9, 16'd4939};

        #3 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_ctrl dut%0d", d), 72'({busy[d], en[d], valid[d], addr[d]}), 72'd0);
            chk($sformatf("reset_win dut%0d", d), win[d], 72'd0);
        end
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        // First start lands in the first cycle out of reset.
        for (int i = 0; i < 7; i++) begin
            int d = tbl[i].d;
            r0 = rd_cnt[d];
            la = tbl[i].last;
            run(d, tbl[i].f, tbl[i].x, tbl[i].y);
            chk($sformatf("n_reads #%0d", i), 72'(rd_cnt[d] - r0), 72'(tbl[i].n));
            chk($sformatf("last_addr #%0d", i), 72'(last_addr[d]), 72'(la));
            chk($sformatf("w22 #%0d", i), 72'(last_win[d][71:64]), 72'(la[7:0]));
            chk($sformatf("idle_busy #%0d", i), 72'(busy[d]), 72'd0);
            if (i == 0) chk("prime_w12", 72'(last_win[0][47:40]), 72'hE2);
            if (i == 1) begin
                chk("slide_w00", 72'(last_win[0][7:0]), 72'h01);
                chk("slide_w02", 72'(last_win[0][23:16]), 72'h03);
                chk("slide_w22", 72'(last_win[0][71:64]), 72'hC3);
            end
            if (i == 2)
                for (int r = 0; r < 3; r++)
                    chk($sformatf("corner_col2_eq_col1 r%0d", r),
                        72'(last_win[0][(3*r+2)*8 +: 8]), 72'(last_win[0][(3*r+1)*8 +: 8]));
        end

        // ROM_LAT=2 slide; start pulses while busy must be ignored.
        r0 = rd_cnt[1];
        v0 = vcnt[1];
        start[1] = 1'b1; first[1] = 1'b0; xs[1] = 8'd10; ys[1] = 8'd20;
        expect_start(1, 1'b0, 10, 20);
        @(negedge clk); #1 start[1] = 1'b0;
        @(negedge clk); #1 start[1] = 1'b1;
        repeat (4) begin @(negedge clk); #1; end
        start[1] = 1'b0;
        wait_done(1);
        repeat (6) @(negedge clk);
        #1;
        chk("lat2_n_reads", 72'(rd_cnt[1] - r0), 72'd3);
        chk("lat2_last_addr", 72'(last_addr[1]), 72'd4940);
        chk("lat2_valid_pulses", 72'(vcnt[1] - v0), 72'd1);

        // Back-to-back slides with i_start held high.
        v0 = vcnt[0];
        start[0] = 1'b1; first[0] = 1'b0; xs[0] = 8'd102; ys[0] = 8'd50;
        expect_start(0, 1'b0, 102, 50);
        r0 = 0;
        while (vcnt[0] == v0 && r0 < 40) begin
            @(negedge clk); #1;
            r0++;
        end
        if (vcnt[0] == v0) fail("b2b_first_valid");
        xs[0] = 8'd103;
        expect_start(0, 1'b0, 103, 50);
        @(negedge clk); #1;
        start[0] = 1'b0;
        chk("b2b_en_after_valid", 72'(en[0]), 72'd1);
        wait_done(0);
        repeat (10) @(negedge clk);
        #1;
        chk("b2b_valid_pulses", 72'(vcnt[0] - v0), 72'd2);

        // Reset during the 4th read of a prime.
        v0 = vcnt[0];
        r0 = rd_cnt[0];
        start[0] = 1'b1; first[0] = 1'b1; xs[0] = 8'd30; ys[0] = 8'd40;
        expect_start(0, 1'b1, 30, 40);
        @(negedge clk); #1 start[0] = 1'b0;
        for (int t = 0; t < 20 && (rd_cnt[0] - r0) < 4; t++) begin
            @(negedge clk); #1;
        end
        chk("abort_reads_before_rst", 72'(rd_cnt[0] - r0), 72'd4);
        rst = 1'b1;
        #1;
        chk("abort_ctrl", 72'({busy[0], en[0], valid[0], addr[0]}), 72'd0);
        chk("abort_win", win[0], 72'd0);
        for (int d = 0; d < 2; d++) begin
            qa[d].delete(); qw[d].delete(); qc[d].delete(); mwin[d] = '0;
        end
        @(negedge clk); #1 rst = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        chk("abort_no_valid", 72'(vcnt[0] - v0), 72'd0);
        chk("abort_win_held", win[0], 72'd0);
        chk("abort_no_reads", 72'(rd_cnt[0] - r0), 72'd4);
        run(0, 1'b1, 5, 5);
        chk("post_abort_w00", 72'(last_win[0][7:0]), 72'h65);
        chk("post_abort_w22", 72'(last_win[0][71:64]), 72'h27);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/window_fetch_ctrl.md
WINDOW_FETCH_CTRL -- requirements
Module: window_fetch_ctrl

Interface
REQ-001 Parameters SHALL be: IMG_W, 224, image width in pixels; IMG_H, 224, image height in lines; DATA_W, 8, pixel width; ADDR_W, 16, ROM address width; ROM_LAT, 1, ROM read latency in cycles (legal 1..2).
REQ-002 i_clk  in  1  single clock; all state on rising edge.
REQ-003 i_rst  in  1  asynchronous, active-high reset.
REQ-004 i_start  in  1  request to fetch a window; sampled only in IDLE.
REQ-005 i_first  in  1  with i_start: 1 = prime a full 3-column window, 0 = fetch one new column and slide.
REQ-006 i_x  in  8  window left column (0..IMG_W-1); i_y  in  8  window top row (0..IMG_H-1); both sampled with i_start.
REQ-007 o_rom_en  out  1  ROM read strobe; o_rom_addr  out  ADDR_W  ROM read address.
REQ-008 i_rom_data  in  DATA_W  ROM read data, valid ROM_LAT cycles after the o_rom_en cycle.
REQ-009 o_busy  out  1  high in every state except IDLE.
REQ-010 o_win  out  9*DATA_W  window, element w[r][c] (r,c in 0..2) at bits [(3r+c)*DATA_W +: DATA_W].
REQ-011 o_win_valid  out  1  one-cycle pulse; o_win updated and stable.

Function
REQ-012 FSM SHALL have states IDLE, ISSUE, DRAIN; i_start=1 in IDLE latches i_x, i_y, i_first and enters ISSUE; i_start outside IDLE is ignored.
REQ-013 Read count N SHALL be 9 when i_first=1, 3 when i_first=0.
REQ-014 In ISSUE, o_rom_en SHALL be high for exactly N consecutive cycles, one address per cycle, then FSM enters DRAIN.
REQ-015 Read order SHALL be column-major, row-minor: prime columns x, x+1, x+2; slide column x+2 only; rows y, y+1, y+2 within each column.
REQ-016 Column SHALL clamp to min(col, IMG_W-1), row to min(row, IMG_H-1) (edge replication); no wrap-around.
REQ-017 o_rom_addr SHALL equal row*IMG_W + col, computed at ADDR_W bits without overflow (max 50175).
REQ-018 Capture SHALL use a ROM_LAT-deep valid shift register tracking o_rom_en; each returned pixel is stored into a 3-entry column buffer at its row index.
REQ-019 When a column's third pixel is captured, o_win SHALL shift left one column (w[r][0]<=w[r][1], w[r][1]<=w[r][2], w[r][2]<=new[r]) on the following edge.
REQ-020 DRAIN SHALL exit to IDLE on the edge performing the last column shift; o_win_valid SHALL be registered high on that same edge (first IDLE cycle), for one cycle.
REQ-021 Latency: i_start sampled at edge T0 -> o_rom_en high cycles T0+1..T0+N -> o_win_valid high in cycle T0+N+ROM_LAT+1.
REQ-022 i_start high in the o_win_valid cycle SHALL be accepted (back-to-back windows, no idle gap).
REQ-023 o_win SHALL hold its value between updates; outside ISSUE, o_rom_en SHALL be 0 and o_rom_addr SHALL hold the last value.
REQ-024 Slide request (i_first=0) with i_x=IMG_W-1 SHALL fetch clamped column IMG_W-1.

Reset
REQ-025 i_rst SHALL immediately force IDLE, o_busy=0, o_rom_en=0, o_rom_addr=0, o_win_valid=0, o_win=0, column buffer and valid pipeline cleared.
REQ-026 Reset mid-ISSUE/DRAIN SHALL abort: no o_win_valid, no o_win update, and ROM data still arriving after release SHALL be discarded.
REQ-027 First i_start after reset release SHALL be accepted in the first cycle i_rst is low.

Verification
REQ-028 Prime, ROM_LAT=1, ROM[a]=a[7:0], i_x=0, i_y=0: addresses 0,224,448,1,225,449,2,226,450; o_win_valid at T0+11; w[1][2]=226[7:0]=0xE2.
REQ-029 Slide after REQ-028 with i_x=1, i_y=0: addresses 3,227,451; o_win_valid at T0+5; w[0][0]=1, w[0][2]=3, w[2][2]=451[7:0]=0xC3.
REQ-030 Corner, i_first=1, i_x=222, i_y=222: columns 222,223,223, rows 222,223,223; last address 50175; column 2 equals column 1.
REQ-031 Back-to-back: i_start held high through two slides -> second window's o_rom_en begins the cycle after the first o_win_valid; exactly two valid pulses.
REQ-032 i_rst asserted at 4th read of a prime -> all outputs 0 same cycle; no o_win_valid within 20 cycles; subsequent prime at x=5,y=5 yields correct window.
REQ-033 ROM_LAT=2, slide at x=10, y=20: addresses 4492,4716,4940; o_win_valid at T0+6; i_start in ISSUE/DRAIN ignored.
